// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one shift per clock.
// Results are registered once per conversion, so bcd_out/ndigits never show partial values.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            ndigits
);

  localparam int unsigned SW = 4 * DIGITS + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        scratch_q, adjusted;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q, done_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [3:0]           ndigits_q, ndigits_calc;
  logic                 load, shift_en, finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StShift;
      StShift:  if (cnt_q == CW'(1)) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    load     = (state_q == StIdle) && start;
    shift_en = (state_q == StShift);
    finish   = (state_q == StFinish);
  end

  // Every BCD nibble >= 5 gets +3 in parallel before the shift.
  always_comb begin
    adjusted = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[WIDTH+4*i +: 4] >= 4'd5) begin
        adjusted[WIDTH+4*i +: 4] = scratch_q[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    ndigits_calc = 4'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[WIDTH+4*i +: 4] != 4'd0) ndigits_calc = 4'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ndigits_q <= 4'd1;
    end else begin
      done_q <= finish;
      if (load) begin
        scratch_q <= {{(4*DIGITS){1'b0}}, bin_in};
        cnt_q     <= CW'(WIDTH);
        busy_q    <= 1'b1;
      end
      if (shift_en) begin
        scratch_q <= adjusted << 1;
        cnt_q     <= cnt_q - CW'(1);
      end
      if (finish) begin
        bcd_q     <= scratch_q[SW-1 -: 4*DIGITS];
        ndigits_q <= ndigits_calc;
        busy_q    <= 1'b0;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ndigits = ndigits_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed protocol cases plus random values
// compared against a divide-by-10 reference model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [39:0] bcd_out;
  logic [3:0]  ndigits;

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;

  bin2bcd_seq #(
    .WIDTH  (32),
    .DIGITS (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ndigits (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && done) done_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] bcd_ref(input logic [31:0] v);
    logic [39:0] r;
    longint unsigned t;
    r = '0;
    t = longint'(v);
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] nd_ref(input logic [31:0] v);
    longint unsigned t;
    int n;
    t = longint'(v);
    n = 1;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return 4'(n);
  endfunction

  task automatic launch(input logic [31:0] v);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = $urandom;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic await_done(output int edges);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic convert(input logic [31:0] v, input string tag);
    int edges;
    launch(v);
    check_eq({tag, "_busy_run"}, 64'(busy), 64'd1);
    await_done(edges);
    check_eq({tag, "_latency"}, 64'(edges), 64'd33);
    check_eq({tag, "_bcd"}, 64'(bcd_out), 64'(bcd_ref(v)));
    check_eq({tag, "_nd"}, 64'(ndigits), 64'(nd_ref(v)));
    check_eq({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int e;
    int d0;
    logic [31:0] a, b, v;
    logic [31:0] sweep [6];
    sweep[0] = 32'd9;         sweep[1] = 32'd10;  sweep[2] = 32'd99;
    sweep[3] = 32'd100;       sweep[4] = 32'd999999999;
    sweep[5] = 32'd1000000000;

    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_bcd", 64'(bcd_out), 64'd0);
    check_eq("rst_nd", 64'(ndigits), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    convert(32'd0, "zero");
    check_eq("zero_bcd_const", 64'(bcd_out), 64'h0);
    convert(32'hFFFF_FFFF, "max");
    check_eq("max_bcd_const", 64'(bcd_out), 64'h42_9496_7295);
    check_eq("max_nd_const", 64'(ndigits), 64'd10);
    convert(32'd1234, "v1234");
    check_eq("v1234_bcd_const", 64'(bcd_out), 64'h1234);
    for (int i = 0; i < 6; i++) convert(sweep[i], "sweep");
    check_eq("sweep_last_nd", 64'(ndigits), 64'd10);

    // start held high with bin_in churning during a conversion
    d0 = done_cnt;
    @(negedge clk);
    bin_in = 32'd5678;
    start  = 1'b1;
    @(posedge clk);
    #1;
    e = 0;
    while (!done && e < 200) begin
      bin_in = $urandom;
      @(posedge clk);
      #1;
      e++;
    end
    start = 1'b0;
    check_eq("hold_latency", 64'(e), 64'd33);
    check_eq("hold_bcd", 64'(bcd_out), 64'h5678);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_done_count", 64'(done_cnt - d0), 64'd1);

    // back-to-back: start in the done cycle
    launch(32'd1234);
    await_done(e);
    check_eq("b2b_first_bcd", 64'(bcd_out), 64'h1234);
    start  = 1'b1;
    bin_in = 32'd42;
    @(posedge clk);
    #1;
    start = 1'b0;
    await_done(e);
    check_eq("b2b_spacing", 64'(e + 1), 64'd34);
    check_eq("b2b_bcd", 64'(bcd_out), 64'h42);
    check_eq("b2b_nd", 64'(ndigits), 64'd2);
    @(posedge clk);
    #1;

    // reset abort mid-conversion
    launch(32'd87654321);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_bcd", 64'(bcd_out), 64'd0);
    check_eq("abort_nd", 64'(ndigits), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("abort_bcd_hold", 64'(bcd_out), 64'd0);
    convert(32'd7, "after_abort");
    check_eq("after_abort_const", 64'(bcd_out), 64'h7);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      unique case (i % 4)
        0: v = a;
        1: v = 32'($urandom_range(0, 99999));
        2: begin b = 32'($urandom_range(1, 65535)); v = a / b; end
        default: begin b = 32'($urandom_range(1, 1000000)); v = a % b; end
      endcase
      convert(v, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
